// File: rtl/line_buf_ctrl_pkg.sv
// Shared types and constants for the line buffer sequencer.
package line_buf_pkg;

  localparam int DATA_WIDTH = 12;
  localparam int WIN_SIZE   = 3;
  localparam int FILL_ROWS  = WIN_SIZE - 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Width of a coordinate able to hold 0..n-1 (at least one bit).
  function automatic int coord_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/line_buf_ctrl_if.sv
// Pixel-source / window-consumer handshake bundle for line_buf_ctrl.
interface line_buf_ctrl_if #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
);
  import line_buf_pkg::*;

  localparam int CW = coord_w(IMG_WIDTH);
  localparam int RW = coord_w(IMG_HEIGHT);

  logic          sof;
  logic          pix_valid;
  logic          pix_ready;
  logic          lb_en;
  logic          win_valid;
  logic          win_ready;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          frame_done;
  logic          busy;

  modport master (
    output sof, pix_valid, win_ready,
    input  pix_ready, lb_en, win_valid, win_row, win_col, frame_done, busy
  );

  modport slave (
    input  sof, pix_valid, win_ready,
    output pix_ready, lb_en, win_valid, win_row, win_col, frame_done, busy
  );

endinterface

// File: rtl/line_buf_ctrl_raster_counter.sv
// Column/row raster position counter with clear, enable and end-of-frame flag.
module raster_counter
  import line_buf_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  localparam int CW = coord_w(IMG_WIDTH),
  localparam int RW = coord_w(IMG_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          col_last,
  output logic          last
);

  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0] col_d, col_q;
  logic [RW-1:0] row_d, row_q;

  // Advance one pixel; wrap column at end of line, wrap both after the last pixel.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (en) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col      = col_q;
  assign row      = row_q;
  assign col_last = (col_q == COL_MAX);
  assign last     = (col_q == COL_MAX) && (row_q == ROW_MAX);

endmodule

// File: rtl/line_buf_ctrl.sv
// Sequences the 3x3 line buffers: shift enable, window qualification, backpressure.
module line_buf_ctrl
  import line_buf_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic           clk,
  input  logic           rst,
  line_buf_ctrl_if.slave bus
);

  localparam int CW = coord_w(IMG_WIDTH);
  localparam int RW = coord_w(IMG_HEIGHT);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] FILL   = ST_FILL;
  localparam logic [1:0] ACTIVE = ST_ACTIVE;
  localparam logic [1:0] DONE   = ST_DONE;

  localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(FILL_ROWS);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(FILL_ROWS);
  localparam logic [RW-1:0] ROW_LAST_FILL = RW'(FILL_ROWS - 1);

  logic [1:0]    state_d, state_q;
  logic          win_valid_d, win_valid_q;
  logic [RW-1:0] win_row_d, win_row_q;
  logic [CW-1:0] win_col_d, win_col_q;
  logic          frame_done_d, frame_done_q;

  logic          pix_ready, in_frame, lb_en, adv, qualify;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_last, last;

  // Handshake: stall the source only while a window is waiting to be consumed.
  always_comb begin
    pix_ready = !(win_valid_q && !bus.win_ready);
    in_frame  = (state_q == FILL) || (state_q == ACTIVE);
    lb_en     = bus.pix_valid && pix_ready && in_frame;
    adv       = lb_en && !bus.sof;  // sof drops any coincident pixel
    qualify   = adv && (row >= ROW_FIRST_WIN) && (col >= COL_FIRST_WIN);
  end

  raster_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .en      (adv),
    .clr     (bus.sof),
    .col     (col),
    .row     (row),
    .col_last(col_last),
    .last    (last)
  );

  // Frame sequencing; sof restarts from any state.
  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    if (bus.sof) begin
      state_d = FILL;
    end else begin
      case (state_q)
        FILL:    if (adv && col_last && (row == ROW_LAST_FILL)) state_d = ACTIVE;
        ACTIVE:  if (adv && last) begin
                   state_d      = DONE;
                   frame_done_d = 1'b1;
                 end
        default: state_d = state_q;
      endcase
    end
  end

  // Window flag: set by a qualifying accept, held under backpressure, cleared on consume or sof.
  always_comb begin
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    if (bus.sof) begin
      win_valid_d = 1'b0;
    end else if (qualify) begin
      win_valid_d = 1'b1;
      win_row_d   = row - RW'(1);
      win_col_d   = col - CW'(1);
    end else if (bus.win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  // Control and window registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_valid_q  <= win_valid_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.pix_ready  = pix_ready;
  assign bus.lb_en      = lb_en;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = in_frame;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Scoreboard bench for line_buf_ctrl on an 8x6 image.
module tb_line_buf_ctrl;

  localparam int W = 8;
  localparam int H = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_buf_ctrl_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();

  line_buf_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int win_seen = 0;
  int fd_seen = 0;
  int exp_frames = 0;
  logic [5:0] exp_q[$];

  // Bench-side raster model
  bit bm_in = 0;
  int bm_r = 0;
  int bm_c = 0;
  bit fd_exp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every consumed window must match the oldest expected one.
  always @(negedge clk) begin
    if (bus.win_valid === 1'b1 && bus.win_ready === 1'b1) begin
      win_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window: got (%0d,%0d) required none", bus.win_row, bus.win_col);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        chk("win_coord", {26'd0, bus.win_row, bus.win_col}, {26'd0, e});
      end
    end
    if (bus.frame_done === 1'b1) fd_seen++;
  end

  task automatic step(input logic v, input logic s, input logic wr, input logic r);
    @(posedge clk);
    #1;
    bus.pix_valid = v;
    bus.sof       = s;
    bus.win_ready = wr;
    rst           = r;
    @(negedge clk);
  endtask

  task automatic common();
    chk("busy", {31'd0, bus.busy}, {31'd0, bm_in});
    chk("frame_done", {31'd0, bus.frame_done}, {31'd0, fd_exp});
    fd_exp = 0;
  endtask

  task automatic pix();
    step(1'b1, 1'b0, 1'b1, 1'b0);
    common();
    chk("lb_en", {31'd0, bus.lb_en}, {31'd0, bm_in});
    chk("pix_ready", {31'd0, bus.pix_ready}, 32'd1);
    if (bm_in) begin
      if (bm_r >= 2 && bm_c >= 2) exp_q.push_back({3'(bm_r - 1), 3'(bm_c - 1)});
      if (bm_c == W - 1) begin
        bm_c = 0;
        if (bm_r == H - 1) begin
          bm_r = 0;
          bm_in = 0;
          fd_exp = 1;
          exp_frames++;
        end else bm_r++;
      end else bm_c++;
    end
  endtask

  task automatic pixels(input int n);
    for (int i = 0; i < n; i++) pix();
  endtask

  task automatic sof_step(input logic v);
    step(v, 1'b1, 1'b1, 1'b0);
    common();
    chk("lb_en_sof", {31'd0, bus.lb_en}, {31'd0, (v && bm_in)});
    bm_in = 1;
    bm_r = 0;
    bm_c = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      common();
      chk("lb_en_idle", {31'd0, bus.lb_en}, 32'd0);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_win_valid", {31'd0, bus.win_valid}, 32'd0);
    chk("rst_win_row", {29'd0, bus.win_row}, 32'd0);
    chk("rst_win_col", {29'd0, bus.win_col}, 32'd0);
    chk("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_pix_ready", {31'd0, bus.pix_ready}, 32'd1);
    chk("rst_lb_en", {31'd0, bus.lb_en}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ws0;
    bus.sof = 1'b0;
    bus.pix_valid = 1'b0;
    bus.win_ready = 1'b1;

    // Reset: the pixel on the bus while reset is sampled must be ignored
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk_reset_vals();

    // Pixels before any sof are discarded
    pixels(3);

    // Frame A: back-to-back, always ready
    sof_step(1'b0);
    ws0 = win_seen;
    pixels(W * H);
    idle(2);
    chk("frameA_windows", win_seen - ws0, 24);
    chk("frameA_queue", exp_q.size(), 0);

    // Frame B: stall 5 cycles at first window
    sof_step(1'b0);
    ws0 = win_seen;
    pixels(19);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      common();
      chk("stall_pix_ready", {31'd0, bus.pix_ready}, 32'd0);
      chk("stall_lb_en", {31'd0, bus.lb_en}, 32'd0);
      chk("stall_win_valid", {31'd0, bus.win_valid}, 32'd1);
      chk("stall_win_row", {29'd0, bus.win_row}, 32'd1);
      chk("stall_win_col", {29'd0, bus.win_col}, 32'd1);
    end
    pixels(W * H - 19);
    idle(2);
    chk("frameB_windows", win_seen - ws0, 24);
    chk("frameB_queue", exp_q.size(), 0);

    // Pixels after frame_done are discarded; sof mid-frame drops pixel #30
    pixels(3);
    ws0 = win_seen;
    sof_step(1'b0);
    pixels(29);
    sof_step(1'b1);
    pix();
    chk("sof_win_cleared", {31'd0, bus.win_valid}, 32'd0);
    pixels(W * H - 1);
    idle(2);
    chk("frameC_windows", win_seen - ws0, 9 + 24);
    chk("frameC_queue", exp_q.size(), 0);

    // Reset pulse at accept #25
    sof_step(1'b0);
    pixels(24);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    bm_in = 0;
    bm_r = 0;
    bm_c = 0;
    fd_exp = 0;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk_reset_vals();
    pixels(3);
    ws0 = win_seen;
    sof_step(1'b0);
    pixels(W * H);
    idle(2);
    chk("frameD_windows", win_seen - ws0, 24);
    chk("frameD_queue", exp_q.size(), 0);

    chk("frame_done_pulses", fd_seen, exp_frames);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
